// File: rtl/vend_ctrl_param.sv
// Parametrised vending-machine controller: product select, coin credit with overflow
// rejection, payment timeout, refund, change and runtime restock. All outputs registered.
module vend_ctrl_param #(
   parameter int                          N_PROD   = 5,
   parameter int                          MONEY_W  = 6,
   parameter int                          QTY_W    = 4,
   parameter logic [N_PROD*MONEY_W-1:0]   PRICES   = {6'd11, 6'd4, 6'd9, 6'd5, 6'd6},
   parameter logic [N_PROD*QTY_W-1:0]     QTY_INIT = {4'd2, 4'd3, 4'd1, 4'd4, 4'd10},
   parameter int                          TIMEOUT  = 30
) (
   input  logic               clk_1ms,
   input  logic               rst,
   input  logic               tick_1s,
   input  logic               key_vld,
   input  logic [3:0]         key,
   input  logic               refund_req,
   input  logic               btn,
   input  logic               rs_vld,
   input  logic [2:0]         rs_id,
   input  logic [QTY_W-1:0]   rs_qty,
   output logic [2:0]         ps,
   output logic [3:0]         curr_prod,
   output logic [MONEY_W-1:0] curr_price,
   output logic [MONEY_W-1:0] money,
   output logic [MONEY_W-1:0] change,
   output logic               dispense,
   output logic               coin_rej,
   output logic               sold_out
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SEL    = 3'd1;
   localparam logic [2:0] S_PAY    = 3'd2;
   localparam logic [2:0] S_DISP   = 3'd3;
   localparam logic [2:0] S_CHNG   = 3'd4;
   localparam logic [2:0] S_REFUND = 3'd5;
   localparam logic [2:0] S_STOCK  = 3'd6;

   localparam logic [3:0] KEY_P0 = 4'hA;

   // Timer only needs to hold 0..TIMEOUT-1; the last value triggers the refund.
   localparam int               TMR_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [QTY_W-1:0]   stock [N_PROD];
   logic [TMR_W-1:0]   timer;
   logic               disp_first;

   logic [2:0]         nxt_ps;
   logic [3:0]         nxt_prod;
   logic [MONEY_W-1:0] nxt_price;
   logic [MONEY_W-1:0] nxt_money;
   logic [MONEY_W-1:0] nxt_change;
   logic [TMR_W-1:0]   nxt_timer;
   logic               nxt_first;
   logic               nxt_rej;

   logic               is_coin;
   logic               is_prod;
   logic               key_empty;
   logic [MONEY_W-1:0] key_price;
   logic [MONEY_W-1:0] coin_val;
   logic [MONEY_W:0]   coin_sum;
   logic               coin_ovf;
   logic               dec_now;

   function automatic logic [QTY_W-1:0] sat_dec(input logic [QTY_W-1:0] q);
      return (q == '0) ? '0 : q - QTY_W'(1);
   endfunction

   // Key decode and credit arithmetic; the extra sum bit flags an overflowing coin.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      is_coin   = key_vld && (key == 4'h1 || key == 4'h2 || key == 4'h5);
      is_prod   = 1'b0;
      key_price = '0;
      key_empty = 1'b0;
      for (int i = 0; i < N_PROD; i++) begin
         if (key_vld && key == KEY_P0 + 4'(i)) begin
            is_prod   = 1'b1;
            key_price = PRICES[i*MONEY_W +: MONEY_W];
            key_empty = (stock[i] == '0);
         end
      end
      coin_val = MONEY_W'(key);
      coin_sum = {1'b0, money} + {1'b0, coin_val};
      coin_ovf = coin_sum[MONEY_W];
   end

   assign dec_now = (ps == S_DISP) && disp_first;

   always_comb begin
      nxt_ps     = ps;
      nxt_prod   = curr_prod;
      nxt_price  = curr_price;
      nxt_money  = money;
      nxt_change = change;
      nxt_timer  = timer;
      nxt_first  = 1'b0;
      nxt_rej    = 1'b0;

      case (ps)
         S_IDLE: begin
            if (is_prod) begin
               nxt_prod  = key;
               nxt_price = key_price;
               nxt_ps    = key_empty ? S_STOCK : S_SEL;
            end else if (is_coin) begin
               nxt_rej = 1'b1;
            end
         end

         S_SEL: begin
            if (refund_req) begin
               nxt_ps  = S_IDLE;
               nxt_rej = is_coin;
            end else if (is_prod) begin
               nxt_prod  = key;
               nxt_price = key_price;
               nxt_ps    = key_empty ? S_STOCK : S_SEL;
            end else if (is_coin) begin
               if (coin_ovf) begin
                  nxt_rej = 1'b1;
               end else begin
                  nxt_money = coin_sum[MONEY_W-1:0];
                  nxt_timer = '0;
                  nxt_ps    = S_PAY;
               end
            end
         end

         S_PAY: begin
            // Cancel wins over everything, then a completed payment, then new credit.
            if (refund_req) begin
               nxt_ps     = S_REFUND;
               nxt_change = money;
               nxt_rej    = is_coin;
            end else if (money >= curr_price) begin
               nxt_ps    = S_DISP;
               nxt_first = 1'b1;
               nxt_rej   = is_coin;
            end else if (is_coin && !coin_ovf) begin
               nxt_money = coin_sum[MONEY_W-1:0];
               nxt_timer = '0;
            end else begin
               nxt_rej = is_coin;
               if (TIMEOUT != 0 && tick_1s) begin
                  if (timer == TMO_LAST) begin
                     nxt_ps     = S_REFUND;
                     nxt_change = money;
                  end else begin
                     nxt_timer = timer + TMR_W'(1);
                  end
               end
            end
         end

         S_DISP: begin
            nxt_rej = is_coin;
            if (disp_first && money > curr_price) begin
               nxt_ps     = S_CHNG;
               nxt_change = money - curr_price;
            end else if (btn) begin
               nxt_ps = S_IDLE;
            end
         end

         S_CHNG, S_REFUND, S_STOCK: begin
            nxt_rej = is_coin;
            if (btn) nxt_ps = S_IDLE;
         end

         default: nxt_ps = S_IDLE;
      endcase

      if (nxt_ps == S_IDLE) begin
         nxt_prod   = '0;
         nxt_price  = '0;
         nxt_money  = '0;
         nxt_change = '0;
         nxt_timer  = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_1ms) begin
      if (rst) begin
         ps         <= S_IDLE;
         curr_prod  <= '0;
         curr_price <= '0;
         money      <= '0;
         change     <= '0;
         timer      <= '0;
         disp_first <= 1'b0;
         coin_rej   <= 1'b0;
         dispense   <= 1'b0;
         sold_out   <= 1'b0;
      end else begin
         ps         <= nxt_ps;
         curr_prod  <= nxt_prod;
         curr_price <= nxt_price;
         money      <= nxt_money;
         change     <= nxt_change;
         timer      <= nxt_timer;
         disp_first <= nxt_first;
         coin_rej   <= nxt_rej;
         dispense   <= (nxt_ps == S_DISP) || (nxt_ps == S_CHNG);
         sold_out   <= (nxt_ps == S_STOCK);
      end
   end

   // Stock table: reset must reload it, so it is a register array rather than a RAM.
   // NOTE: the table is reset explicitly because a mid-operation reset must restore QTY_INIT.
   always_ff @(posedge clk_1ms) begin
      for (int i = 0; i < N_PROD; i++) begin
         if (rst) begin
            stock[i] <= QTY_INIT[i*QTY_W +: QTY_W];
         end else if (rs_vld && rs_id == 3'(i)) begin
            stock[i] <= (dec_now && curr_prod == KEY_P0 + 4'(i)) ? sat_dec(rs_qty) : rs_qty;
         end else if (dec_now && curr_prod == KEY_P0 + 4'(i)) begin
            stock[i] <= sat_dec(stock[i]);
         end
      end
   end

endmodule
